quantum_scheduler: RTL and testbench

//  Time-sliced round-robin scheduler that shares the coprocessor datapath between

---
 rtl/quantum_scheduler.sv | 141 ++++++++++++++
 tb/tb_quantum_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_scheduler.sv
// Time-sliced round-robin scheduler: one requester owns the coprocessor for at most
// QUANTUM cycles under contention, then priority rotates past it.
module quantum_scheduler #(
   parameter int WIDTH   = 4,
   parameter int QUANTUM = 8,
   localparam int ID_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int CNT_W  = (QUANTUM > 2) ? $clog2(QUANTUM) : 1
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic [WIDTH-1:0] in_request,
   input  logic [WIDTH-1:0] in_done,
   output logic [WIDTH-1:0] out_grant,
   output logic [ID_W-1:0]  out_grant_id,
   output logic             out_busy,
   output logic             out_preempt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               busy_q, busy_d;
   logic               preempt_q, preempt_d;

   logic [2*WIDTH-1:0] double_req;
   logic [2*WIDTH-1:0] double_pick;
   logic [WIDTH-1:0]   pick;
   logic [ID_W-1:0]    pick_id;
   logic [WIDTH-1:0]   others;
   logic [WIDTH-1:0]   grant_rotl;
   logic               release_now;

   // Circular find-first from ptr: duplicating the request vector lets the borrow
   // chain of the subtraction wrap around past the top bit.
   always_comb begin
      double_req  = {in_request, in_request};
      double_pick = double_req & ~(double_req - {{WIDTH{1'b0}}, ptr_q});
      pick        = double_pick[WIDTH-1:0] | double_pick[2*WIDTH-1:WIDTH];
      pick_id     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pick[i]) pick_id = ID_W'(i);
      end
   end

   always_comb begin
      others      = in_request & ~grant_q;
      grant_rotl  = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
      release_now = ((in_request & grant_q) == '0) || ((in_done & grant_q) != '0);

      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      preempt_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_request != '0) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (pick != '0) begin
               grant_d    = pick;
               grant_id_d = pick_id;
               busy_d     = 1'b1;
               cnt_d      = '0;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Release outranks expiry so a finishing owner never sees a preempt pulse.
            if (release_now) begin
               grant_d    = '0;
               grant_id_d = '0;
               busy_d     = 1'b0;
               ptr_d      = grant_rotl;
               state_d    = (others != '0) ? ST_ARB : ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               if (others != '0) begin
                  grant_d    = '0;
                  grant_id_d = '0;
                  busy_d     = 1'b0;
                  preempt_d  = 1'b1;
                  ptr_d      = grant_rotl;
                  state_d    = ST_ARB;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
            cnt_d      = '0;
         end
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= WIDTH'(1);
         cnt_q      <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
      end
   end

   assign out_grant    = grant_q;
   assign out_grant_id = grant_id_q;
   assign out_busy     = busy_q;
   assign out_preempt  = preempt_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Bench for quantum_scheduler: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a cycle-level behavioural model.
module tb_quantum_scheduler;

   localparam int W = 4;
   localparam int Q = 4;

   logic         in_clk = 1'b0;
   logic         in_reset;
   logic [W-1:0] in_request;
   logic [W-1:0] in_done;
   logic [W-1:0] out_grant;
   logic [1:0]   out_grant_id;
   logic         out_busy;
   logic         out_preempt;

   int checks = 0;
   int errors = 0;

   // Model state: phase 0=idle 1=arbitrating 2=owner running; used = cycles granted so far.
   int   m_phase;
   int   m_owner;
   int   m_used;
   int   m_prio;
   logic m_preempt;

   quantum_scheduler #(.WIDTH(W), .QUANTUM(Q)) dut (
      .in_clk       (in_clk),
      .in_reset     (in_reset),
      .in_request   (in_request),
      .in_done      (in_done),
      .out_grant    (out_grant),
      .out_grant_id (out_grant_id),
      .out_busy     (out_busy),
      .out_preempt  (out_preempt)
   );

   always #5 in_clk = ~in_clk;

   function automatic logic [W-1:0] exp_grant();
      logic [W-1:0] g;
      g = '0;
      if (m_phase == 2) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_owner   = 0;
      m_used    = 0;
      m_prio    = 0;
      m_preempt = 1'b0;
   endtask

   task automatic model_edge(input logic [W-1:0] req, input logic [W-1:0] done);
      bit found;
      bit rivals;
      int idx;
      m_preempt = 1'b0;
      rivals = 0;
      for (int j = 0; j < W; j++) if (j != m_owner && req[j]) rivals = 1;
      case (m_phase)
         0: if (req != '0) m_phase = 1;
         1: begin
            found = 0;
            for (int k = 0; k < W; k++) begin
               idx = (m_prio + k) % W;
               if (!found && req[idx]) begin
                  found   = 1;
                  m_owner = idx;
               end
            end
            if (found) begin
               m_phase = 2;
               m_used  = 1;
            end else begin
               m_phase = 0;
            end
         end
         default: begin
            if (!req[m_owner] || done[m_owner]) begin
               m_prio  = (m_owner + 1) % W;
               m_phase = rivals ? 1 : 0;
            end else if (m_used == Q) begin
               if (rivals) begin
                  m_preempt = 1'b1;
                  m_prio    = (m_owner + 1) % W;
                  m_phase   = 1;
               end else begin
                  m_used = 1;
               end
            end else begin
               m_used++;
            end
         end
      endcase
   endtask

   task automatic apply_stimulus(input logic [W-1:0] req, input logic [W-1:0] done);
      logic [W-1:0] g;
      in_request = req;
      in_done    = done;
      @(posedge in_clk);
      model_edge(req, done);
      #2;
      g = exp_grant();
      check_output("grant", 32'(out_grant), 32'(g));
      check_output("grant_id", 32'(out_grant_id), (m_phase == 2) ? 32'(m_owner) : 32'd0);
      check_output("busy", 32'(out_busy), 32'(m_phase == 2));
      check_output("preempt", 32'(out_preempt), 32'(m_preempt));
   endtask

   task automatic do_reset();
      in_reset   = 1'b0;
      in_request = '0;
      in_done    = '0;
      model_reset();
      repeat (2) @(posedge in_clk);
      #2;
      in_reset = 1'b1;
   endtask

   initial begin
      logic [W-1:0] req;
      logic [W-1:0] done;
      int slot;

      do_reset();
      check_output("reset_grant", 32'(out_grant), 32'd0);
      check_output("reset_busy", 32'(out_busy), 32'd0);
      check_output("reset_preempt", 32'(out_preempt), 32'd0);

      // Lone requester: granted two edges later and renewed forever.
      apply_stimulus(4'b0100, '0);
      check_output("single_arb", 32'(out_grant), 32'd0);
      apply_stimulus(4'b0100, '0);
      check_output("single_grant", 32'(out_grant), 32'b0100);
      for (int n = 0; n < 18; n++) begin
         apply_stimulus(4'b0100, '0);
         check_output("single_hold", 32'(out_grant), 32'b0100);
         check_output("single_nopre", 32'(out_preempt), 32'd0);
      end

      // Full contention: Q cycles per owner, one gap cycle carrying the preempt pulse.
      do_reset();
      for (int n = 1; n <= 22; n++) begin
         apply_stimulus(4'b1111, '0);
         if (n < 2) begin
            check_output("rr_start", 32'(out_grant), 32'd0);
         end else begin
            slot = (n - 2) % 5;
            if (slot < 4) begin
               check_output("rr_grant", 32'(out_grant), 32'(1 << (((n - 2) / 5) % 4)));
               check_output("rr_id", 32'(out_grant_id), 32'(((n - 2) / 5) % 4));
               check_output("rr_nopre", 32'(out_preempt), 32'd0);
            end else begin
               check_output("rr_gap", 32'(out_grant), 32'd0);
               check_output("rr_pre", 32'(out_preempt), 32'd1);
            end
         end
      end

      // Early done releases without a preempt pulse and moves priority on.
      do_reset();
      apply_stimulus(4'b0110, '0);
      apply_stimulus(4'b0110, '0);
      check_output("done_first", 32'(out_grant), 32'b0010);
      apply_stimulus(4'b0110, '0);
      check_output("done_second", 32'(out_grant), 32'b0010);
      apply_stimulus(4'b0110, 4'b0010);
      check_output("done_drop", 32'(out_grant), 32'd0);
      check_output("done_nopre", 32'(out_preempt), 32'd0);
      apply_stimulus(4'b0110, '0);
      check_output("done_next", 32'(out_grant), 32'b0100);

      // Withdrawn request while running, then withdrawn during arbitration.
      do_reset();
      apply_stimulus(4'b0001, '0);
      apply_stimulus(4'b0001, '0);
      check_output("wd_grant", 32'(out_grant), 32'b0001);
      apply_stimulus(4'b0000, '0);
      check_output("wd_drop", 32'(out_grant), 32'd0);
      check_output("wd_busy", 32'(out_busy), 32'd0);
      apply_stimulus(4'b0010, '0);
      apply_stimulus(4'b0000, '0);
      check_output("arb_wd", 32'(out_grant), 32'd0);
      apply_stimulus(4'b0000, '0);
      check_output("arb_wd_idle", 32'(out_grant), 32'd0);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      apply_stimulus(4'b1000, '0);
      apply_stimulus(4'b1000, '0);
      apply_stimulus(4'b1000, '0);
      check_output("rst_pre_grant", 32'(out_grant), 32'b1000);
      #3;
      in_reset = 1'b0;
      #1;
      check_output("rst_async_grant", 32'(out_grant), 32'd0);
      check_output("rst_async_busy", 32'(out_busy), 32'd0);
      model_reset();
      in_request = '0;
      repeat (2) @(posedge in_clk);
      #2;
      in_reset = 1'b1;
      apply_stimulus(4'b1001, '0);
      apply_stimulus(4'b1001, '0);
      check_output("rst_ptr_home", 32'(out_grant), 32'b0001);

      // Random sticky requests with occasional done pulses, model checked every cycle.
      req = '0;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, 99) < 15) req[b] = ~req[b];
         end
         done = '0;
         if ($urandom_range(0, 7) == 0) done = exp_grant();
         if ($urandom_range(0, 5) == 0) done = done | W'($urandom_range(0, 15));
         apply_stimulus(req, done);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
